// File: rtl/mult_arb_pkg.sv
// Shared types, default sizes and the round-robin pick helper for mult_arbiter.
package mult_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEFAULT_NREQ = 4;
    localparam int DEFAULT_W    = 4;
    localparam int MAX_NREQ     = 8;

    // Lowest set bit at or above ptr; if none, lowest set bit overall.
    // Callers zero-pad the request vector above their own NREQ.
    function automatic logic [2:0] rr_pick(input logic [MAX_NREQ-1:0] vld,
                                           input logic [2:0]          ptr);
        logic [MAX_NREQ-1:0] masked;
        logic [2:0]          idx;
        logic                found;
        masked = vld & (8'hFF << ptr);
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (!found && masked[i]) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (!found && vld[i]) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/array_multiplier.sv
// Combinational unsigned W x W array multiplier: shifted partial-product rows summed.
module array_multiplier #(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    logic [2*W-1:0] pp [W];

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_row
            assign pp[gi] = b[gi] ? ({{W{1'b0}}, a} << gi) : '0;
        end
    endgenerate

    // Accumulate the partial-product rows.
    always_comb begin
        p = '0;
        for (int i = 0; i < W; i++) begin
            p = p + pp[i];
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sequencing NREQ requesters through one shared array multiplier.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = DEFAULT_NREQ,
    parameter int W    = DEFAULT_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*W-1:0]    res_p,
    output logic [IDW-1:0]    res_id,
    output logic              busy,
    output logic [7:0]        res_count
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]     op_a_q, op_a_d;
    logic [W-1:0]     op_b_q, op_b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [2*W-1:0]   res_p_q, res_p_d;
    logic [IDW-1:0]   res_id_q, res_id_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       res_count_q, res_count_d;

    logic [MAX_NREQ-1:0] vld_pad;
    logic [2:0]          pick;
    logic [IDW-1:0]      grant;
    logic [2*W-1:0]      product;

    // Shared datapath, fed only from the operand registers.
    array_multiplier #(.W(W)) u_mul (
        .a (op_a_q),
        .b (op_b_q),
        .p (product)
    );

    // Widen the request vector and pointer to the helper's fixed width.
    always_comb begin
        vld_pad             = '0;
        vld_pad[NREQ-1:0]   = req_valid;
        pick                = rr_pick(vld_pad, 3'(ptr_q));
        grant               = IDW'(pick);
    end

    // Next-state logic: grant in IDLE, load the product in MUL, handshake in HOLD.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        id_d        = id_q;
        res_p_d     = res_p_q;
        res_id_d    = res_id_q;
        res_count_d = res_count_q;
        req_ready   = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready[grant] = 1'b1;
                    op_a_d           = req_a[grant*W +: W];
                    op_b_d           = req_b[grant*W +: W];
                    id_d             = grant;
                    ptr_d            = (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
                    state_d          = MUL;
                end
            end
            MUL: begin
                res_p_d  = product;
                res_id_d = id_q;
                state_d  = HOLD;
            end
            HOLD: begin
                if (res_ready) begin
                    res_count_d = res_count_q + 8'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered from the state being entered.
        res_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
    end

    // All state, including the registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            id_q        <= '0;
            res_p_q     <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            res_count_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            id_q        <= id_d;
            res_p_q     <= res_p_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            res_count_q <= res_count_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_p     = res_p_q;
    assign res_id    = res_id_q;
    assign busy      = busy_q;
    assign res_count = res_count_q;

endmodule
